host_tx_arb: RTL and testbench



---
 rtl/host_tx_arb_pkg.sv | 23 ++
 rtl/host_tx_arb_rr_pick.sv | 32 +++
 rtl/host_tx_arb.sv | 162 ++++++++++++++++
 tb/tb_host_tx_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_tx_arb_pkg.sv
// Shared definitions for the host UART transmit arbiter: FSM state codes,
// default sizing and the round-robin pointer helper.
package host_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_LEN_W   = 5;
  localparam int DEF_TIMEOUT = 1023;

  // Next round-robin start point: one past v, wrapping n-1 back to 0.
  function automatic int wrap_inc(input int v, input int n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/host_tx_arb_rr_pick.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping,
// and returns the first set bit as a one-hot grant plus its index.
module host_tx_arb_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      logic [IW-1:0] jj;
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/host_tx_arb.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among
// N_REQ byte-stream requesters, with a per-byte busy-rise timeout.
module host_tx_arb
  import host_tx_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [N_REQ*8-1:0]     data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [7:0]             tx_data,
  output logic                   tx_send,
  input  logic                   tx_busy,
  output logic                   timeout_err,
  output logic [2:0]             status
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [LEN_W-1:0] len_a  [N_REQ];
  logic [7:0]       data_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign len_a[i]  = len[i*LEN_W +: LEN_W];
    assign data_a[i] = data[i*8 +: 8];
  end

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_send_q, tx_send_d;
  logic             to_q, to_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  host_tx_arb_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Every transition into DONE also drops gnt, so gnt falls together with
  // the end of the packet rather than one cycle later.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    to_d      = 1'b0;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    timer_d   = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          rem_d   = len_a[pick_idx];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (rem_q == '0 || !req[idx_q]) begin
          gnt_d   = '0;
          state_d = ST_DONE;
        end else if (!tx_busy) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_data_d    = data_a[idx_q];
        tx_send_d    = 1'b1;
        ack_d[idx_q] = 1'b1;
        rem_d        = rem_q - 1'b1;
        timer_d      = '0;
        state_d      = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else if (timer_q == TW'(TIMEOUT)) begin
          to_d    = 1'b1;
          gnt_d   = '0;
          state_d = ST_DONE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (rem_q != '0 && req[idx_q]) begin
            state_d = ST_SEND;
          end else begin
            gnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        ptr_d   = IW'(wrap_inc(int'(idx_q), N_REQ));
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      to_q      <= 1'b0;
      ptr_q     <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      to_q      <= to_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      timer_q   <= timer_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign tx_data     = tx_data_q;
  assign tx_send     = tx_send_q;
  assign timeout_err = to_q;
  assign status      = state_q;

endmodule

// File: tb/tb_host_tx_arb.sv
// Randomized scoreboard bench for host_tx_arb: requester and UART models,
// a packet-level arbitration model, and a decoupled output monitor.
module tb_host_tx_arb;

  localparam int N  = 4;
  localparam int LW = 5;
  localparam int T  = 20;

  logic              clk;
  logic              nRst;
  logic [N-1:0]      req, gnt, ack;
  logic [N*LW-1:0]   len;
  logic [N*8-1:0]    data;
  logic [7:0]        tx_data;
  logic              tx_send, tx_busy, timeout_err;
  logic [2:0]        status;

  logic [7:0]        data_a [N];
  logic [LW-1:0]     len_a  [N];
  logic [7:0]        pkt_b  [N][32];
  int                pkt_drop [N];
  int                launch   [N];
  int                busy_len, dead_launch;
  bit                uart_stuck;
  int                errors, checks, cyc, last_send, nsend, mptr;

  typedef struct {int idx; logic [7:0] b;} exp_t;
  exp_t exp_b[$];
  int   exp_g[$];
  int   exp_to[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign data[i*8 +: 8]   = data_a[i];
    assign len[i*LW +: LW]  = len_a[i];
  end

  host_tx_arb #(.N_REQ(N), .LEN_W(LW), .TIMEOUT(T)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .req         (req),
    .len         (len),
    .data        (data),
    .gnt         (gnt),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err),
    .status      (status)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Packet-level model: all requests in mask are pending together while idle,
  // so the service order is a pure pointer scan; push expectations, then launch.
  task automatic launch_round(input logic [N-1:0] mask, input int ln [N],
                              input int drop [N], input bit tmo, input int base);
    logic [N-1:0] pend;
    bit first;
    int w, nb;
    exp_t e;
    for (int i = 0; i < N; i++)
      if (mask[i])
        for (int k = 0; k < 32; k++)
          pkt_b[i][k] = (base >= 0) ? 8'(base + k) : 8'($urandom);
    pend  = mask;
    first = 1'b1;
    while (pend != '0) begin
      w  = pick(pend, mptr);
      nb = ln[w];
      if (drop[w] > 0 && drop[w] < nb) nb = drop[w];
      if (tmo && first && nb > 0) begin
        nb = 1;
        exp_to.push_back(w);
      end
      exp_g.push_back(w);
      for (int k = 0; k < nb; k++) begin
        e.idx = w;
        e.b   = pkt_b[w][k];
        exp_b.push_back(e);
      end
      pend[w] = 1'b0;
      mptr    = (w + 1) % N;
      first   = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (mask[i]) begin
        len_a[i]    = LW'(ln[i]);
        pkt_drop[i] = drop[i];
        launch[i]   = launch[i] + 1;
      end
    if (tmo) dead_launch++;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      @(negedge clk);
      ok = (req == '0) && (status == 3'd0) && (exp_b.size() == 0) &&
           (exp_g.size() == 0) && (exp_to.size() == 0);
    end
    chk({nm, "_complete"}, 32'(ok), 1);
    if (!ok) begin
      exp_b.delete();
      exp_g.delete();
      exp_to.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Requester model: raises req on launch, steps data on ack, drops req on
  // its drop point, when its grant falls, or on reset.
  task automatic req_proc();
    int pos [N];
    int seen [N];
    logic [N-1:0] prev_g;
    for (int i = 0; i < N; i++) begin
      pos[i]  = 0;
      seen[i] = 0;
    end
    prev_g = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!nRst) begin
          req[i] = 1'b0;
        end else if (req[i]) begin
          if (ack[i] && pos[i] < 31) begin
            pos[i]++;
            data_a[i] = pkt_b[i][pos[i]];
            if (pkt_drop[i] != 0 && pos[i] == pkt_drop[i]) req[i] = 1'b0;
          end
          if (prev_g[i] && !gnt[i]) req[i] = 1'b0;
        end else if (launch[i] != seen[i]) begin
          seen[i]   = launch[i];
          pos[i]    = 0;
          data_a[i] = pkt_b[i][0];
          req[i]    = 1'b1;
        end
        prev_g[i] = gnt[i];
      end
    end
  endtask

  // UART model: busy for busy_len cycles per send; a "dead" phase ignores
  // sends until the arbiter reports a timeout.
  task automatic uart_proc();
    int cnt, dseen;
    bit dead;
    cnt   = 0;
    dseen = 0;
    dead  = 1'b0;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        cnt  = 0;
        dead = 1'b0;
      end else begin
        if (dead_launch != dseen) begin
          dseen = dead_launch;
          dead  = 1'b1;
        end
        if (timeout_err) dead = 1'b0;
        if (tx_send && !dead) cnt = busy_len;
        else if (cnt > 0) cnt--;
      end
      tx_busy = uart_stuck || (cnt > 0);
    end
  endtask

  task automatic monitor();
    logic prev_send;
    logic [N-1:0] prev_gnt;
    exp_t e;
    int g;
    prev_send = 1'b0;
    prev_gnt  = '0;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        prev_send = 1'b0;
        prev_gnt  = '0;
      end else begin
        cyc++;
        if (tx_send) begin
          chk("send_gap", 32'(prev_send), 0);
          chk("send_queued", 32'(exp_b.size() > 0), 1);
          if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            chk("tx_data", 32'(tx_data), 32'(e.b));
            chk("send_gnt", 32'(gnt), 32'(1) << e.idx);
            chk("send_ack", 32'(ack), 32'(1) << e.idx);
          end
          last_send = cyc;
          nsend++;
        end else if (ack != '0) begin
          chk("stray_ack", 32'(ack), 0);
        end
        if (gnt != '0 && prev_gnt == '0) begin
          chk("gnt_queued", 32'(exp_g.size() > 0), 1);
          if (exp_g.size() > 0) begin
            g = exp_g.pop_front();
            chk("gnt_order", 32'(gnt), 32'(1) << g);
          end
        end
        if (timeout_err) begin
          chk("to_queued", 32'(exp_to.size() > 0), 1);
          if (exp_to.size() > 0) void'(exp_to.pop_front());
          chk("to_delay", 32'(cyc - last_send), 32'(T + 1));
          chk("to_gnt", 32'(gnt), 0);
        end
        prev_send = tx_send;
        prev_gnt  = gnt;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_gnt"},     32'(gnt), 0);
    chk({nm, "_ack"},     32'(ack), 0);
    chk({nm, "_tx_data"}, 32'(tx_data), 0);
    chk({nm, "_tx_send"}, 32'(tx_send), 0);
    chk({nm, "_to"},      32'(timeout_err), 0);
    chk({nm, "_status"},  32'(status), 0);
  endtask

  initial begin
    int z [N];
    int ns0;
    bit found;
    errors = 0; checks = 0; cyc = 0; last_send = 0; nsend = 0; mptr = 0;
    busy_len = 10; dead_launch = 0; uart_stuck = 1'b0;
    nRst = 1'b0; req = '0; tx_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      z[i] = 0; data_a[i] = '0; len_a[i] = '0; pkt_drop[i] = 0; launch[i] = 0;
    end
    fork
      req_proc();
      uart_proc();
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    // single 3-byte packet on requester 0, bytes A0..A2
    busy_len = 10;
    launch_round(4'b0001, '{3, 0, 0, 0}, z, 1'b0, 8'hA0);
    wait_idle("single");

    // all four single-byte packets, then wrap of the pointer
    busy_len = 2;
    launch_round(4'b1111, '{1, 1, 1, 1}, z, 1'b0, -1);
    wait_idle("all_four");
    launch_round(4'b0100, '{0, 0, 2, 0}, z, 1'b0, -1);
    wait_idle("to_ptr3");
    launch_round(4'b0011, '{1, 1, 0, 0}, z, 1'b0, -1);
    wait_idle("wrap");
    launch_round(4'b1000, '{0, 0, 0, 1}, z, 1'b0, -1);
    wait_idle("to_ptr0");

    // requester 1 times out on its first byte, requester 2 then served
    busy_len = 1;
    launch_round(4'b0110, '{0, 4, 2, 0}, z, 1'b1, -1);
    wait_idle("timeout");

    // requester 0 drops req after its second ack
    busy_len = 2;
    launch_round(4'b0001, '{5, 0, 0, 0}, '{2, 0, 0, 0}, 1'b0, -1);
    wait_idle("drop");

    // empty packet: grant only
    launch_round(4'b0100, '{0, 0, 0, 0}, z, 1'b0, -1);
    wait_idle("len0");

    // UART busy at grant: must hold in LOAD without sending
    ns0 = nsend;
    uart_stuck = 1'b1;
    launch_round(4'b1000, '{0, 0, 0, 2}, z, 1'b0, -1);
    repeat (30) @(negedge clk);
    chk("stuck_load", 32'(status), 1);
    chk("stuck_nosend", 32'(nsend), 32'(ns0));
    uart_stuck = 1'b0;
    wait_idle("stuck");

    // reset in WAIT_LO of a 4-byte packet; pointer was 3 beforehand
    launch_round(4'b0100, '{0, 0, 1, 0}, z, 1'b0, -1);
    wait_idle("pre_reset");
    busy_len = 3;
    launch_round(4'b0001, '{4, 0, 0, 0}, z, 1'b0, -1);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      found = (status == 3'd4);
    end
    chk("reach_wait_lo", 32'(found), 1);
    nRst = 1'b0;
    #1;
    chk_reset_outputs("midpkt_reset");
    exp_b.delete();
    exp_g.delete();
    exp_to.delete();
    mptr = 0;
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    busy_len = 2;
    launch_round(4'b1010, '{0, 2, 0, 2}, z, 1'b0, -1);
    wait_idle("post_reset");

    // randomized rounds
    for (int r = 0; r < 10; r++) begin
      logic [N-1:0] m;
      int ln [N];
      int dr [N];
      m = N'($urandom_range(1, (1 << N) - 1));
      busy_len = $urandom_range(1, 4);
      for (int i = 0; i < N; i++) begin
        ln[i] = $urandom_range(0, 6);
        dr[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      launch_round(m, ln, dr, 1'b0, -1);
      wait_idle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
